// File: rtl/tx_os_generator_if.sv
// tx_os_generator_if: ordered-set stream between the TX ordered-set generator and the lane transmit path.
//   orderedSets : 16 lanes x 128 bits, lane i at [128i+127:128i], symbol k at [8k+7:8k] of a lane
//   laneValid   : per-lane valid, only for active lanes while osValid is set
//   osValid     : ordered sets presented (valid half of the valid/ready handshake)
//   txReady     : lane path accepts the presented ordered sets
interface tx_os_generator_if;
  logic [2047:0] orderedSets;
  logic [15:0] laneValid;
  logic osValid;
  logic txReady;
  modport master(output orderedSets, laneValid, osValid, input txReady);
  modport slave(input orderedSets, laneValid, osValid, output txReady);
endinterface

// File: rtl/tx_os_generator.sv
// tx_os_generator: builds TS1/TS2/EIOS ordered sets for up to 16 lanes and streams them until the command completes.
//   clk, reset (async, active low)
//   start/stop        : command pulse (IDLE only) / abort (SEND only)
//   osType, gen, linkNumber, rateId, trainingCtrl, padLink, padLane, minCount, numberOfDetectedLanes : captured on start
//   rxFinish          : receive-side exit condition, live during SEND
//   os                : ordered-set stream (orderedSets, laneValid, osValid out; txReady in)
//   finish            : one-cycle completion pulse
//   sentCount         : accepted sets for the current command, saturating at 2047
//   txElectricalIdle  : set after an EIOS command completes, cleared by start
module tx_os_generator #(
  parameter logic [7:0] NFTS = 8'd16,
  parameter int LANES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stop,
  input  logic [1:0] osType,
  input  logic [2:0] gen,
  input  logic [7:0] linkNumber,
  input  logic [7:0] rateId,
  input  logic [7:0] trainingCtrl,
  input  logic padLink,
  input  logic padLane,
  input  logic [10:0] minCount,
  input  logic [4:0] numberOfDetectedLanes,
  input  logic rxFinish,
  tx_os_generator_if.master os,
  output logic finish,
  output logic [10:0] sentCount,
  output logic txElectricalIdle
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state;
  logic isEios, rxSeen, lowGen, eios, ts2, xfer, complete;
  logic [10:0] minCountR, nextCount;
  logic [4:0] laneCount;
  logic [LANES-1:0] laneMask;
  logic [128*LANES-1:0] build;
  logic [7:0] s0, fill, linkSym;
  logic [127:0] eiosLane;
  assign laneCount = numberOfDetectedLanes > 5'd16 ? 5'd16 : numberOfDetectedLanes;
  assign lowGen = gen <= 3'd2;
  assign eios = osType == 2'b10;
  assign ts2 = osType == 2'b01;
  assign s0 = lowGen ? 8'hBC : ts2 ? 8'h2D : 8'h1E;
  assign fill = ts2 ? 8'h45 : 8'h4A;
  assign linkSym = padLink ? 8'hF7 : linkNumber;
  assign eiosLane = lowGen ? {96'h0, 8'h7C, 8'h7C, 8'h7C, 8'hBC} : {16{8'h66}};
  // The whole command's payload is fixed at start, so it is built from the live inputs and registered once.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign laneMask[i] = 5'(i) < laneCount;
    assign build[128*i +: 128] = !laneMask[i] ? '0 : eios ? eiosLane :
      {{10{fill}}, trainingCtrl, rateId, NFTS, padLane ? 8'hF7 : 8'(i), linkSym, s0};
  end
  assign xfer = state == SEND && os.txReady;
  assign nextCount = sentCount == 11'd2047 ? sentCount : sentCount + 11'd1;
  // rxFinish in the completing cycle counts even before it has been latched into rxSeen.
  assign complete = xfer && (isEios || (nextCount >= minCountR && (rxSeen || rxFinish)));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      isEios <= 1'b0;
      minCountR <= '0;
      rxSeen <= 1'b0;
      sentCount <= '0;
      finish <= 1'b0;
      txElectricalIdle <= 1'b1;
      os.osValid <= 1'b0;
      os.orderedSets <= '0;
      os.laneValid <= '0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= SEND;
          isEios <= eios;
          minCountR <= minCount;
          sentCount <= '0;
          rxSeen <= 1'b0;
          txElectricalIdle <= 1'b0;
          os.osValid <= 1'b1;
          os.orderedSets <= build;
          os.laneValid <= laneMask;
        end
        SEND: begin
          if (xfer) sentCount <= nextCount;
          rxSeen <= rxSeen | rxFinish;
          // stop wins over a completing transfer: the count still advances but no finish is raised
          if (stop || complete) begin
            state <= stop ? IDLE : DONE;
            finish <= !stop;
            txElectricalIdle <= txElectricalIdle | (!stop && isEios);
            os.osValid <= 1'b0;
            os.orderedSets <= '0;
            os.laneValid <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tx_os_generator.sv
// tb_tx_os_generator: table-driven and randomized checking of tx_os_generator against a symbol-level reference model.
module tb_tx_os_generator;
  typedef struct {
    logic [1:0] osType;
    logic [2:0] gen;
    logic [7:0] link, rate, tc;
    bit padLink, padLane;
    int minCount, lanes, rxAt, readyPct, expCount;
    bit expEidle;
  } cmd_t;
  logic clk = 0, reset = 0, start = 0, stop = 0, padLink = 0, padLane = 0, rxFinish = 0;
  logic [1:0] osType = 0;
  logic [2:0] gen = 1;
  logic [7:0] linkNumber = 0, rateId = 0, trainingCtrl = 0;
  logic [10:0] minCount = 0;
  logic [4:0] numberOfDetectedLanes = 0;
  logic finish, txElectricalIdle;
  logic [10:0] sentCount;
  int errors = 0, checks = 0;
  cmd_t tbl[7];
  tx_os_generator_if bus();
  tx_os_generator dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .osType(osType), .gen(gen),
    .linkNumber(linkNumber), .rateId(rateId), .trainingCtrl(trainingCtrl), .padLink(padLink),
    .padLane(padLane), .minCount(minCount), .numberOfDetectedLanes(numberOfDetectedLanes),
    .rxFinish(rxFinish), .os(bus), .finish(finish), .sentCount(sentCount),
    .txElectricalIdle(txElectricalIdle)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic chkSets(input string name, input logic [2047:0] act, input logic [2047:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < 16; i++)
        if (act[128*i +: 128] !== exp[128*i +: 128]) begin
          $display("FAIL %s lane %0d actual=%h required=%h", name, i, act[128*i +: 128], exp[128*i +: 128]);
          break;
        end
    end
  endtask
  function automatic logic [2047:0] refSets(input cmd_t c);
    logic [7:0] s[16];
    logic [2047:0] r = '0;
    int n = c.lanes > 16 ? 16 : c.lanes;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 16; k++) s[k] = 8'h00;
      if (c.osType == 2'd2) begin
        if (c.gen <= 2) begin
          s[0] = 8'hBC; s[1] = 8'h7C; s[2] = 8'h7C; s[3] = 8'h7C;
        end else
          for (int k = 0; k < 16; k++) s[k] = 8'h66;
      end else begin
        s[0] = c.gen <= 2 ? 8'hBC : (c.osType == 2'd1 ? 8'h2D : 8'h1E);
        s[1] = c.padLink ? 8'hF7 : c.link;
        s[2] = c.padLane ? 8'hF7 : 8'(i);
        s[3] = 8'd16;
        s[4] = c.rate;
        s[5] = c.tc;
        for (int k = 6; k < 16; k++) s[k] = c.osType == 2'd1 ? 8'h45 : 8'h4A;
      end
      for (int k = 0; k < 16; k++) r[128*i + 8*k +: 8] = s[k];
    end
    return r;
  endfunction
  task automatic checkIdle(input string name);
    chk({name, "_osValid"}, bus.osValid, 0);
    chk({name, "_laneValid"}, bus.laneValid, 0);
    chkSets({name, "_sets"}, bus.orderedSets, '0);
    chk({name, "_finish"}, finish, 0);
  endtask
  task automatic runCmd(input cmd_t c);
    logic [2047:0] exp;
    logic [15:0] mask = '0;
    int model = 0;
    bit seen = 0, done = 0;
    exp = refSets(c);
    for (int i = 0; i < 16 && i < c.lanes; i++) mask[i] = 1'b1;
    @(negedge clk);
    osType = c.osType; gen = c.gen; linkNumber = c.link; rateId = c.rate; trainingCtrl = c.tc;
    padLink = c.padLink; padLane = c.padLane; minCount = 11'(c.minCount);
    numberOfDetectedLanes = 5'(c.lanes); rxFinish = c.rxAt < 0; start = 1;
    @(negedge clk);
    start = 0;
    osType = 2'($urandom); gen = 3'($urandom); linkNumber = 8'($urandom); padLink = 1'($urandom);
    minCount = 11'($urandom); numberOfDetectedLanes = 5'($urandom);
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      chk("osValid", bus.osValid, 1);
      chk("finishLow", finish, 0);
      chk("sentCount", sentCount, 64'(model));
      chk("laneValid", bus.laneValid, mask);
      chk("eidleLow", txElectricalIdle, 0);
      chkSets("sets", bus.orderedSets, exp);
      bus.txReady = $urandom_range(99) < c.readyPct;
      if (c.rxAt >= 0) rxFinish = model >= c.rxAt;
      seen = seen | rxFinish;
      if (bus.txReady) model = model < 2047 ? model + 1 : 2047;
      done = bus.txReady && (c.osType == 2'd2 || (model >= c.minCount && seen));
      @(negedge clk);
    end
    chk("completedInBudget", done, 1);
    chk("finishPulse", finish, 1);
    chk("osValidDone", bus.osValid, 0);
    chk("laneValidDone", bus.laneValid, 0);
    chkSets("setsDone", bus.orderedSets, '0);
    chk("sentCountDone", sentCount, 64'(model));
    chk("eidleDone", txElectricalIdle, c.osType == 2'd2);
    bus.txReady = 0;
    rxFinish = 0;
    @(negedge clk);
    chk("finishOnce", finish, 0);
    chk("sentCountHold", sentCount, 64'(model));
  endtask
  initial begin
    cmd_t c;
    bus.txReady = 0;
    tbl[0] = '{2'd0, 3'd1, 8'd5, 8'h11, 8'h22, 1'b0, 1'b0, 16, 4, 19, 100, 20, 1'b0};
    tbl[1] = '{2'd1, 3'd3, 8'd9, 8'h33, 8'h44, 1'b0, 1'b0, 16, 8, -1, 50, 16, 1'b0};
    tbl[2] = '{2'd2, 3'd2, 8'd1, 8'h00, 8'h00, 1'b0, 1'b0, 100, 16, 0, 100, 1, 1'b1};
    tbl[3] = '{2'd2, 3'd5, 8'd1, 8'h00, 8'h00, 1'b0, 1'b0, 100, 12, 0, 60, 1, 1'b1};
    tbl[4] = '{2'd0, 3'd2, 8'd7, 8'h55, 8'h66, 1'b1, 1'b1, 2, 16, -1, 100, 2, 1'b0};
    tbl[5] = '{2'd1, 3'd4, 8'd3, 8'h12, 8'h34, 1'b0, 1'b0, 0, 6, 3, 100, 4, 1'b0};
    tbl[6] = '{2'd3, 3'd3, 8'd2, 8'hAB, 8'hCD, 1'b0, 1'b1, 1, 20, -1, 100, 1, 1'b0};
    repeat (2) @(negedge clk);
    checkIdle("reset");
    chk("reset_sentCount", sentCount, 0);
    chk("reset_eidle", txElectricalIdle, 1);
    reset = 1;
    foreach (tbl[i]) begin
      runCmd(tbl[i]);
      chk($sformatf("tbl%0d_count", i), sentCount, 64'(tbl[i].expCount));
      chk($sformatf("tbl%0d_eidle", i), txElectricalIdle, tbl[i].expEidle);
    end
    // stop in the same cycle as the completing transfer
    @(negedge clk);
    osType = 0; gen = 1; numberOfDetectedLanes = 2; minCount = 3; rxFinish = 1; start = 1;
    @(negedge clk);
    start = 0; bus.txReady = 1;
    repeat (2) @(negedge clk);
    chk("stop_pre", sentCount, 2);
    stop = 1;
    @(negedge clk);
    stop = 0; bus.txReady = 0; rxFinish = 0;
    checkIdle("stop");
    chk("stop_count", sentCount, 3);
    @(negedge clk);
    checkIdle("stop_after");
    // start during SEND is ignored
    osType = 0; gen = 3; numberOfDetectedLanes = 16; minCount = 5; rxFinish = 1; start = 1;
    @(negedge clk);
    start = 0; bus.txReady = 1;
    repeat (2) @(negedge clk);
    osType = 2; start = 1;
    @(negedge clk);
    start = 0;
    chk("ignStart_count", sentCount, 3);
    chk("ignStart_valid", bus.osValid, 1);
    repeat (2) @(negedge clk);
    chk("ignStart_finish", finish, 1);
    chk("ignStart_count5", sentCount, 5);
    chk("ignStart_eidle", txElectricalIdle, 0);
    bus.txReady = 0; rxFinish = 0;
    @(negedge clk);
    // asynchronous reset mid-SEND
    osType = 0; gen = 1; numberOfDetectedLanes = 8; minCount = 50; start = 1;
    @(negedge clk);
    start = 0; bus.txReady = 1;
    repeat (3) @(negedge clk);
    chk("rst_preCount", sentCount, 3);
    #2 reset = 0;
    #1;
    checkIdle("rstMid");
    chk("rstMid_sentCount", sentCount, 0);
    chk("rstMid_eidle", txElectricalIdle, 1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    checkIdle("rstRelease");
    bus.txReady = 0;
    for (int n = 0; n < 25; n++) begin
      c.osType = 2'($urandom);
      c.gen = 3'($urandom_range(5, 1));
      c.link = 8'($urandom); c.rate = 8'($urandom); c.tc = 8'($urandom);
      c.padLink = 1'($urandom); c.padLane = 1'($urandom);
      c.minCount = int'($urandom_range(20));
      c.lanes = int'($urandom_range(31));
      c.rxAt = $urandom_range(3) == 0 ? -1 : int'($urandom_range(25));
      c.readyPct = int'($urandom_range(100, 30));
      c.expCount = -1; c.expEidle = 0;
      runCmd(c);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
